ps2_key_event_queue: RTL and testbench

Parametrised successor to the basic scan-code decoder for the keyboard path. Consumes the raw byte stream from the PS/2 receiver and decodes E0 (extend) and F0 (break) prefixes. Maintains the 512-bit key_down map and queues discrete key events in a first-word-fall-through FIFO, so the game FSM (Pac-Man direction and menu logic) loses no presses between polls. Adds optional internally generated auto-repeat events for the most recently pressed key.

---
 rtl/ps2_key_event_queue.sv | 159 +++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code decoder: tracks held keys in a 512-bit map and queues make/break/repeat
// events in a first-word-fall-through FIFO for a polling consumer.
module ps2_key_event_queue #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        byte_in,
  input  logic                              byte_valid,
  input  logic                              byte_err,
  output logic [511:0]                      key_down,
  output logic [8:0]                        last_change,
  output logic [8:0]                        evt_code,
  output logic                              evt_break,
  output logic                              evt_repeat,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   evt_count,
  output logic                              overflow,
  input  logic                              clr_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e          state_q, state_d;
  logic [511:0]    key_down_q;
  logic [8:0]      last_change_q;
  logic            rep_armed_q;
  logic [CNT_W-1:0] rep_cnt_q;
  logic [8:0]      rep_code_q;
  logic [10:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;

  logic       ev_fire, ev_brk, ev_ext, self_test;
  logic [8:0] ev_code;
  logic       par_push, rep_req, push_req, push_ok, pop;
  logic [10:0] push_data, head;

  always_comb begin
    state_d   = state_q;
    ev_fire   = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    self_test = 1'b0;
    if (byte_err) begin
      state_d = StIdle;
    end else if (byte_valid) begin
      state_d = StIdle;
      unique case (state_q)
        StIdle: begin
          if (byte_in == 8'hE0)      state_d = StExt;
          else if (byte_in == 8'hF0) state_d = StBrk;
          else if (byte_in == 8'hAA) self_test = 1'b1;
          else if (!(byte_in inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) ev_fire = 1'b1;
        end
        StExt: begin
          if (byte_in == 8'hF0) begin
            state_d = StExtBrk;
          end else begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
          end
        end
        StBrk: begin
          ev_fire = 1'b1;
          ev_brk  = 1'b1;
        end
        StExtBrk: begin
          ev_fire = 1'b1;
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
        end
      endcase
    end
  end

  assign ev_code = {ev_ext, byte_in};
  // Makes of held keys (device typematic) and breaks of released keys produce nothing.
  assign par_push  = ev_fire & (ev_brk ? key_down_q[ev_code] : !key_down_q[ev_code]);
  assign rep_req   = (REPEAT_EN != 0) && rep_armed_q && (rep_cnt_q == '0);
  assign push_req  = par_push | rep_req;
  assign push_data = par_push ? {ev_code, ev_brk, 1'b0} : {rep_code_q, 1'b0, 1'b1};
  assign pop       = (count_q != '0) & evt_ready;
  assign push_ok   = push_req & ((count_q != CntW'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      key_down_q    <= '0;
      last_change_q <= '0;
      rep_armed_q   <= 1'b0;
      rep_cnt_q     <= '0;
      rep_code_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (self_test) begin
        key_down_q    <= '0;
        last_change_q <= '0;
      end else if (par_push) begin
        key_down_q[ev_code] <= !ev_brk;
        last_change_q       <= ev_code;
      end

      if (REPEAT_EN != 0) begin
        if (self_test) begin
          rep_armed_q <= 1'b0;
        end else if (par_push && !ev_brk) begin
          rep_armed_q <= 1'b1;
          rep_code_q  <= ev_code;
          rep_cnt_q   <= CNT_W'(REPEAT_DELAY - 1);
        end else if (par_push && ev_brk && ev_code == rep_code_q) begin
          rep_armed_q <= 1'b0;
        end else if (rep_armed_q) begin
          // A repeat that loses arbitration waits at zero for the next free cycle.
          if (rep_cnt_q == '0) begin
            if (!par_push) rep_cnt_q <= CNT_W'(REPEAT_PERIOD - 1);
          end else begin
            rep_cnt_q <= rep_cnt_q - 1'b1;
          end
        end
      end

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_ok) - CntW'(pop);

      if (push_req && !push_ok) overflow_q <= 1'b1;
      else if (clr_overflow)    overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head        = mem[rd_ptr_q];
  assign evt_valid   = (count_q != '0);
  assign evt_code    = evt_valid ? head[10:2] : '0;
  assign evt_break   = evt_valid & head[1];
  assign evt_repeat  = evt_valid & head[0];
  assign evt_count   = count_q;
  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench: instance a has no auto-repeat and a 4-deep queue, instance b exercises
// auto-repeat timing with a short delay/period.
module tb_ps2_key_event_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst, a_valid, a_err, a_ready, a_clr;
  logic [7:0]   a_byte;
  logic [511:0] a_key_down;
  logic [8:0]   a_last, a_code;
  logic         a_brk, a_rep, a_evt_valid, a_ovf;
  logic [2:0]   a_count;

  logic         b_rst, b_valid, b_err, b_ready, b_clr;
  logic [7:0]   b_byte;
  logic [511:0] b_key_down;
  logic [8:0]   b_last, b_code;
  logic         b_brk, b_rep, b_evt_valid, b_ovf;
  logic [3:0]   b_count;

  int n_chk  = 0;
  int n_pass = 0;

  ps2_key_event_queue #(
    .FIFO_DEPTH(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CNT_W(8)
  ) u_a (
    .clk(clk), .rst(a_rst), .byte_in(a_byte), .byte_valid(a_valid), .byte_err(a_err),
    .key_down(a_key_down), .last_change(a_last), .evt_code(a_code), .evt_break(a_brk),
    .evt_repeat(a_rep), .evt_valid(a_evt_valid), .evt_ready(a_ready), .evt_count(a_count),
    .overflow(a_ovf), .clr_overflow(a_clr)
  );

  ps2_key_event_queue #(
    .FIFO_DEPTH(8), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst(b_rst), .byte_in(b_byte), .byte_valid(b_valid), .byte_err(b_err),
    .key_down(b_key_down), .last_change(b_last), .evt_code(b_code), .evt_break(b_brk),
    .evt_repeat(b_rep), .evt_valid(b_evt_valid), .evt_ready(b_ready), .evt_count(b_count),
    .overflow(b_ovf), .clr_overflow(b_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input bit b, input logic [7:0] v);
    if (b) begin b_byte = v; b_valid = 1'b1; end
    else   begin a_byte = v; a_valid = 1'b1; end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic pop(input bit b, input string tag, input logic [8:0] code,
                     input logic brk, input logic rep);
    check({tag, "_valid"}, b ? b_evt_valid : a_evt_valid, 1);
    check({tag, "_code"}, b ? b_code : a_code, code);
    check({tag, "_brk"}, b ? b_brk : a_brk, brk);
    check({tag, "_rep"}, b ? b_rep : a_rep, rep);
    if (b) b_ready = 1'b1; else a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    b_ready = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_err = 1'b0; a_ready = 1'b0; a_clr = 1'b0; a_byte = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_err = 1'b0; b_ready = 1'b0; b_clr = 1'b0; b_byte = '0;
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Reset state
    check("rst_count", a_count, 0);
    check("rst_valid", a_evt_valid, 0);
    check("rst_keys", |a_key_down, 0);
    check("rst_last", a_last, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_code", a_code, 0);

    // Single key make/break
    send(0, 8'h1C);
    check("mk_kd", a_key_down[9'h01C], 1);
    check("mk_count", a_count, 1);
    check("mk_last", a_last, 9'h01C);
    send(0, 8'hF0);
    check("f0_kd", a_key_down[9'h01C], 1);
    check("f0_count", a_count, 1);
    send(0, 8'h1C);
    check("br_kd", a_key_down[9'h01C], 0);
    check("br_count", a_count, 2);
    check("br_last", a_last, 9'h01C);
    pop(0, "sk_make", 9'h01C, 0, 0);
    pop(0, "sk_break", 9'h01C, 1, 0);
    check("sk_empty", a_count, 0);

    // Extended key
    send(0, 8'hE0);
    send(0, 8'h75);
    check("ext_kd", a_key_down[9'h175], 1);
    check("ext_kd_base", a_key_down[9'h075], 0);
    pop(0, "ext_make", 9'h175, 0, 0);
    send(0, 8'hE0);
    send(0, 8'hF0);
    send(0, 8'h75);
    check("extbr_kd", a_key_down[9'h175], 0);
    check("extbr_kd_base", a_key_down[9'h075], 0);
    pop(0, "ext_break", 9'h175, 1, 0);

    // Device typematic suppressed
    send(0, 8'h1C);
    send(0, 8'h1C);
    send(0, 8'h1C);
    check("typ_count", a_count, 1);
    pop(0, "typ_make", 9'h01C, 0, 0);
    send(0, 8'hF0);
    send(0, 8'h1C);
    pop(0, "typ_break", 9'h01C, 1, 0);

    // Break of an unheld key, ignored status bytes
    send(0, 8'hF0);
    send(0, 8'h2B);
    send(0, 8'hFA);
    send(0, 8'hEE);
    check("spur_count", a_count, 0);

    // byte_err drops the pending E0
    send(0, 8'hE0);
    a_err = 1'b1;
    tick();
    a_err = 1'b0;
    send(0, 8'h1D);
    check("err_kd_ext", a_key_down[9'h11D], 0);
    pop(0, "err_make", 9'h01D, 0, 0);
    send(0, 8'hF0);
    send(0, 8'h1D);
    pop(0, "err_break", 9'h01D, 1, 0);

    // Overflow with a 4-deep queue
    send(0, 8'h15);
    send(0, 8'h1D);
    send(0, 8'h1C);
    send(0, 8'h1B);
    send(0, 8'h23);
    check("ovf_count", a_count, 4);
    check("ovf_flag", a_ovf, 1);
    check("ovf_keys", {a_key_down[9'h015], a_key_down[9'h01D], a_key_down[9'h01C],
                       a_key_down[9'h01B], a_key_down[9'h023]}, 5'b11111);
    pop(0, "ovf_0", 9'h015, 0, 0);
    pop(0, "ovf_1", 9'h01D, 0, 0);
    pop(0, "ovf_2", 9'h01C, 0, 0);
    pop(0, "ovf_3", 9'h01B, 0, 0);
    check("ovf_drained", a_count, 0);
    check("ovf_sticky", a_ovf, 1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("ovf_clr", a_ovf, 0);

    // Self-test with three keys held and two events queued
    send(0, 8'hF0);
    send(0, 8'h15);
    send(0, 8'hF0);
    send(0, 8'h1D);
    check("aa_pre_count", a_count, 2);
    send(0, 8'hAA);
    check("aa_keys", |a_key_down, 0);
    check("aa_last", a_last, 0);
    check("aa_count", a_count, 2);

    // Asynchronous reset with a pending F0
    send(0, 8'hF0);
    a_rst = 1'b1;
    #2;
    check("arst_count", a_count, 0);
    check("arst_valid", a_evt_valid, 0);
    tick();
    a_rst = 1'b0;
    send(0, 8'h1C);
    check("post_rst_kd", a_key_down[9'h01C], 1);
    pop(0, "post_rst", 9'h01C, 0, 0);

    // Auto-repeat timing, counted from the make push edge
    send(1, 8'h1D);
    check("rep_make", b_count, 1);
    repeat (19) tick();
    check("rep_t19", b_count, 1);
    tick();
    check("rep_t20", b_count, 2);
    repeat (4) tick();
    check("rep_t24", b_count, 2);
    tick();
    check("rep_t25", b_count, 3);
    repeat (4) tick();
    check("rep_t29", b_count, 3);
    tick();
    check("rep_t30", b_count, 4);
    send(1, 8'hF0);
    send(1, 8'h1D);
    check("rep_brk", b_count, 5);
    repeat (30) tick();
    check("rep_stopped", b_count, 5);
    pop(1, "rep_e0", 9'h01D, 0, 0);
    pop(1, "rep_e1", 9'h01D, 0, 1);
    pop(1, "rep_e2", 9'h01D, 0, 1);
    pop(1, "rep_e3", 9'h01D, 0, 1);
    pop(1, "rep_e4", 9'h01D, 1, 0);
    check("rep_empty", b_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
